glitch_pulse_gen: RTL

//  Core timing engine of the glitcher. It is armed with a delay and width, then

---
 rtl/glitcher_pkg.sv | 28 ++
 rtl/glitch_trig_sync.sv | 49 ++++
 rtl/glitch_pulse_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher: FSM state encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a; the front-end status readback decodes the same 2-bit encoding.
package glitcher_pkg;

    // Default counter widths for the pulse engine.
    localparam int GP_DELAY_W_DEF = 16;
    localparam int GP_WIDTH_W_DEF = 8;

    // Fixed 2-bit state encoding; status readback depends on these values.
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ARMED_ENC = 2'd1;
    localparam logic [1:0] ST_DELAY_ENC = 2'd2;
    localparam logic [1:0] ST_PULSE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ARMED = ST_ARMED_ENC,
        ST_DELAY = ST_DELAY_ENC,
        ST_PULSE = ST_PULSE_ENC
    } gp_state_e;

    // Width of a counter that must hold either a delay or a width value.
    function automatic int gp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// Trigger synchronizer + edge detector: SYNC_STAGES flops, one history flop, edge select.
// Latency: an edge on trig_i gives trig_evt_o exactly SYNC_STAGES cycles later, for 1 cycle.
// Backpressure: none; events are single-cycle strobes and are dropped if not consumed.
//
// Ports:
//   clk, rst      single clock, async active-high reset
//   trig_i        raw asynchronous trigger pin
//   fall_sel_i    0 = detect rising edge, 1 = detect falling edge
//   trig_evt_o    1-cycle strobe when the synchronized trigger shows the selected edge
module glitch_trig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    input  logic fall_sel_i,
    output logic trig_evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;
    logic                   synced;

    // Shift the raw pin in at bit 0; the last stage is the synchronized value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trig_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Compare the synced value against the previous synced value. The
    // event is combinational from flops so the FSM can act on it in the
    // same cycle it appears (cycle T of the timing contract).
    assign trig_evt_o = fall_sel_i ? (hist_q & ~synced) : (synced & ~hist_q);

endmodule

// File: rtl/glitch_pulse_gen.sv
// Glitch timing engine: arm with delay/width, wait for trigger edge, emit one timed pulse.
// Latency: trigger event in cycle T -> glitch_o high T+1+D..T+D+W, done_o in T+D+W+1 (T+1+D if W=0).
// Backpressure: none; arm_i is only accepted in IDLE, cancel_i aborts from any state.
//
// Ports:
//   clk, rst      single clock, async active-high reset (glitch_o drops at once)
//   arm_i         strobe: latch delay_i/width_i/trig_fall_i and go ARMED (IDLE only)
//   cancel_i      strobe: abort to IDLE, no done_o; beats a simultaneous arm_i
//   trig_i        raw external trigger, asynchronous
//   trig_fall_i   edge select latched at arm (0 rising, 1 falling)
//   delay_i       cycles from trigger event to pulse start, latched at arm
//   width_i       pulse width in cycles, latched at arm
//   glitch_o      registered glitch pulse
//   armed_o       high in ARMED
//   busy_o        high in ARMED, DELAY or PULSE
//   done_o        1-cycle strobe once a sequence completes
module glitch_pulse_gen
    import glitcher_pkg::*;
#(
    parameter int DELAY_W     = GP_DELAY_W_DEF,
    parameter int WIDTH_W     = GP_WIDTH_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm_i,
    input  logic               cancel_i,
    input  logic               trig_i,
    input  logic               trig_fall_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic [WIDTH_W-1:0] width_i,
    output logic               glitch_o,
    output logic               armed_o,
    output logic               busy_o,
    output logic               done_o
);

    // One down-counter serves both the DELAY and the PULSE phase.
    localparam int CNT_W = gp_max(DELAY_W, WIDTH_W);

    gp_state_e          state_q;
    gp_state_e          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] delay_d;
    logic [WIDTH_W-1:0] width_q;
    logic [WIDTH_W-1:0] width_d;
    logic               trig_fall_q;
    logic               trig_fall_d;
    logic               glitch_q;
    logic               glitch_d;
    logic               done_q;
    logic               done_d;

    logic               trig_evt;
    logic               delay_zero;
    logic               width_zero;
    logic               cnt_last;

    // Edge selection uses the latched polarity so a change on trig_fall_i
    // after arming cannot alter which edge fires the sequence.
    glitch_trig_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk        (clk),
        .rst        (rst),
        .trig_i     (trig_i),
        .fall_sel_i (trig_fall_q),
        .trig_evt_o (trig_evt)
    );

    assign delay_zero = (delay_q == '0);
    assign width_zero = (width_q == '0);

    // The counter is loaded with the full phase length on entry and the
    // phase ends in the cycle it reads 1. Treating 0 as terminal too keeps
    // the counter saturated rather than wrapping should it ever read 0.
    assign cnt_last = (cnt_q <= CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        delay_d     = delay_q;
        width_d     = width_q;
        trig_fall_d = trig_fall_q;
        done_d      = 1'b0;

        if (cancel_i) begin
            // Abort wins over everything, including a coincident arm_i.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Only place the config registers are written.
                    if (arm_i) begin
                        delay_d     = delay_i;
                        width_d     = width_i;
                        trig_fall_d = trig_fall_i;
                        state_d     = ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    // Edges seen during the arm cycle itself landed while
                    // still IDLE, so only post-arm edges reach here.
                    if (trig_evt) begin
                        if (!delay_zero) begin
                            state_d = ST_DELAY;
                            cnt_d   = CNT_W'(delay_q);
                        end else if (!width_zero) begin
                            state_d = ST_PULSE;
                            cnt_d   = CNT_W'(width_q);
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end

                ST_DELAY: begin
                    if (cnt_last) begin
                        if (!width_zero) begin
                            state_d = ST_PULSE;
                            cnt_d   = CNT_W'(width_q);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                ST_PULSE: begin
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // glitch_o is a flop that mirrors the next state, so it is high in
        // exactly the cycles the FSM sits in PULSE, without a comb path.
        glitch_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            trig_fall_q <= 1'b0;
            glitch_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            trig_fall_q <= trig_fall_d;
            glitch_q    <= glitch_d;
            done_q      <= done_d;
        end
    end

    assign glitch_o = glitch_q;
    assign done_o   = done_q;
    assign armed_o  = (state_q == ST_ARMED);
    assign busy_o   = (state_q != ST_IDLE);

endmodule
